// File: rtl/gps_sample_packer.sv
// Packs pairs of 8-bit complex samples into 32-bit words, buffers them in a small FIFO
// and streams them out as AXI4-Stream packets with TLAST every PKT_WORDS words.
module gps_sample_packer #(
  parameter int DEPTH     = 16,
  parameter int PKT_WORDS = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     dv_in,
  input  logic [7:0]               real_in,
  input  logic [7:0]               imag_in,
  output logic [31:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic                     overflow,
  input  logic                     clear_overflow,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = $clog2(PKT_WORDS);

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;

  logic           phase_q, phase_d;
  logic [15:0]    half_q, half_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic           wr_req_q, wr_req_d;
  entry_t         wr_entry_q, wr_entry_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d, mem_cnt;
  logic           out_valid_q, out_valid_d;
  entry_t         out_entry_q, out_entry_d;
  logic           overflow_q, overflow_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  entry_t         mem [DEPTH];

  logic pop, full, wr_accept, wr_drop, load_out, wc_last;

  // Completed words wait one cycle in wr_entry_q; the full/drop decision is taken there.
  assign pop       = out_valid_q & m_tready;
  assign full      = (level_q == LW'(DEPTH));
  assign wr_accept = wr_req_q & (~full | pop);
  assign wr_drop   = wr_req_q & full & ~pop;
  assign mem_cnt   = level_q - LW'(out_valid_q);
  assign load_out  = (mem_cnt != '0) & (~out_valid_q | pop);
  assign wc_last   = (wc_q == WCW'(PKT_WORDS - 1));

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    phase_d    = phase_q;
    half_d     = half_q;
    wc_d       = wc_q;
    wr_req_d   = 1'b0;
    wr_entry_d = wr_entry_q;
    if (!enable) begin
      phase_d = 1'b0;
      wc_d    = '0;
    end else if (dv_in) begin
      if (!phase_q) begin
        half_d  = {imag_in, real_in};
        phase_d = 1'b1;
      end else begin
        wr_req_d   = 1'b1;
        wr_entry_d = '{last: wc_last, data: {imag_in, real_in, half_q}};
        phase_d    = 1'b0;
        wc_d       = wc_last ? '0 : wc_q + WCW'(1);
      end
    end
  end

  always_comb begin
    level_d     = level_q + LW'(wr_accept) - LW'(pop);
    wr_ptr_d    = wr_ptr_q + AW'(wr_accept);
    rd_ptr_d    = rd_ptr_q + AW'(load_out);
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (load_out) begin
      out_valid_d = 1'b1;
      out_entry_d = mem[rd_ptr_q];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = wr_drop ? 16'd1 : 16'd0;
    end else if (wr_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= 1'b0;
      half_q      <= '0;
      wc_q        <= '0;
      wr_req_q    <= 1'b0;
      wr_entry_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      half_q      <= half_d;
      wc_q        <= wc_d;
      wr_req_q    <= wr_req_d;
      wr_entry_q  <= wr_entry_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // NOTE: storage array has no reset; only the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= wr_entry_q;
  end

  assign m_tdata    = out_entry_q.data;
  assign m_tlast    = out_entry_q.last;
  assign m_tvalid   = out_valid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_gps_sample_packer.sv
// Directed + randomized bench for gps_sample_packer; a queue of expected words is
// built from the sample-pairing and packet-length rules and checked on every transfer.
module tb_gps_sample_packer;

  localparam int DEPTH     = 8;
  localparam int PKT_WORDS = 4;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          dv_in = 1'b0;
  logic [7:0]    real_in = '0;
  logic [7:0]    imag_in = '0;
  logic          m_tready = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [LW-1:0] fifo_level;

  gps_sample_packer #(.DEPTH(DEPTH), .PKT_WORDS(PKT_WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dv_in(dv_in),
    .real_in(real_in), .imag_in(imag_in), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .overflow(overflow),
    .clear_overflow(clear_overflow), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  bit          m_phase;
  logic [15:0] m_half;
  int          word_idx;
  int          xfer_cnt;
  int          tlast_cnt;
  bit          hold_pend;
  logic [32:0] held;
  bit          rand_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every transfer must match the head of the expected queue,
  // and a stalled word must stay put until it is taken.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_word", {m_tlast, m_tdata}, held);
      end
      if (m_tvalid && m_tready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("xfer_word", {m_tlast, m_tdata}, exp_q.pop_front());
        xfer_cnt++;
        if (m_tlast) tlast_cnt++;
      end
      hold_pend = m_tvalid && !m_tready;
      held      = {m_tlast, m_tdata};
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_phase  = 1'b0;
    word_idx = 0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    dv_in    = 1'b0;
    m_tready = 1'b0;
    model_reset();
    hold_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One sample strobe; the model pairs samples and queues the resulting word.
  task automatic send_sample(input logic [7:0] r, input logic [7:0] i, input bit accept);
    @(posedge clk);
    #1;
    dv_in = 1'b1; real_in = r; imag_in = i;
    if (rand_ready) m_tready = ($urandom % 4) != 0;
    @(posedge clk);
    #1;
    dv_in = 1'b0;
    if (rand_ready) m_tready = ($urandom % 4) != 0;
    if (!m_phase) begin
      m_half  = {i, r};
      m_phase = 1'b1;
    end else begin
      if (accept) exp_q.push_back({word_idx == PKT_WORDS - 1, i, r, m_half});
      word_idx = (word_idx + 1) % PKT_WORDS;
      m_phase  = 1'b0;
    end
  endtask

  task automatic send_word(input bit accept);
    send_sample(8'($urandom), 8'($urandom), accept);
    send_sample(8'($urandom), 8'($urandom), accept);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("drain_tvalid", m_tvalid, 0);
    check("drain_level", fifo_level, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rand_ready = 1'b0;
    do_reset();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_level", fifo_level, 0);

    // First word and its two-cycle latency.
    enable = 1'b1; m_tready = 1'b1;
    send_sample(8'h01, 8'h02, 1);
    send_sample(8'h03, 8'h04, 1);
    check("lat_n0_tvalid", m_tvalid, 0);
    @(posedge clk); #1;
    check("lat_n1_tvalid", m_tvalid, 0);
    check("lat_n1_level", fifo_level, 1);
    @(posedge clk); #1;
    check("lat_n2_tvalid", m_tvalid, 1);
    check("lat_n2_tdata", m_tdata, 32'h04030201);
    check("lat_n2_tlast", m_tlast, 0);
    wait_drain();

    // Packet boundaries over 16 samples.
    do_reset();
    enable = 1'b1; m_tready = 1'b1;
    xfer_cnt = 0; tlast_cnt = 0;
    for (int k = 0; k < 8; k++) send_word(1);
    wait_drain();
    check("pkt_words", xfer_cnt, 8);
    check("pkt_tlasts", tlast_cnt, 2);
    check("pkt_drops", drop_count, 0);

    // Random data under random back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) send_word(1);
    rand_ready = 1'b0;
    m_tready = 1'b1;
    wait_drain();
    check("rand_drops", drop_count, 0);
    check("rand_overflow", overflow, 0);

    // Fill past capacity with the sink stalled.
    m_tready = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++) send_word(exp_q.size() < DEPTH);
    @(posedge clk); #1;
    check("full_level", fifo_level, DEPTH);
    check("full_overflow", overflow, 1);
    check("full_drops", drop_count, 3);

    // Pop and completed word on the same edge: the word is kept.
    send_word(1);
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    check("popwr_level", fifo_level, DEPTH);
    check("popwr_drops", drop_count, 3);

    // Clear coinciding with a drop.
    send_word(0);
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    check("clrdrop_overflow", overflow, 0);
    check("clrdrop_count", drop_count, 1);
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    check("clr_count", drop_count, 0);

    xfer_cnt = 0;
    m_tready = 1'b1;
    wait_drain();
    check("full_drain_words", xfer_cnt, DEPTH);

    // Enable drop discards the half word and restarts the packet count.
    send_sample(8'hAA, 8'hBB, 1);
    @(posedge clk); #1;
    enable = 1'b0;
    m_phase = 1'b0; word_idx = 0;
    repeat (2) begin
      @(posedge clk); #1;
      dv_in = 1'b1; real_in = 8'h55; imag_in = 8'h66;
      @(posedge clk); #1;
      dv_in = 1'b0;
    end
    enable = 1'b1;
    xfer_cnt = 0; tlast_cnt = 0;
    send_sample(8'h11, 8'h22, 1);
    send_sample(8'h33, 8'h44, 1);
    @(posedge clk); @(posedge clk); #1;
    check("en_word", {m_tlast, m_tdata}, {1'b0, 32'h44332211});
    for (int k = 0; k < PKT_WORDS - 1; k++) send_word(1);
    wait_drain();
    check("en_words", xfer_cnt, PKT_WORDS);
    check("en_tlasts", tlast_cnt, 1);

    // Asynchronous reset in the middle of a stalled packet.
    m_tready = 1'b0;
    for (int k = 0; k < 3; k++) send_word(1);
    send_sample(8'h77, 8'h88, 1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_tvalid", m_tvalid, 0);
    check("arst_tlast", m_tlast, 0);
    check("arst_tdata", m_tdata, 0);
    check("arst_level", fifo_level, 0);
    check("arst_drop", drop_count, 0);
    check("arst_overflow", overflow, 0);
    do_reset();
    enable = 1'b1; m_tready = 1'b1;
    xfer_cnt = 0;
    send_word(1);
    send_word(1);
    wait_drain();
    check("resume_words", xfer_cnt, 2);
    check("resume_drops", drop_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
